// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler in front of the shared 8:1 mux.
// Picks one requester at a time, drives the mux select and a one-hot grant,
// and keeps the owner for up to BURST accepted beats before rotating priority.
//
// Handshake: a beat transfers on any rising edge where out_valid and
// out_ready are both high. out_valid is combinational from req[sel] and may
// drop without a transfer when the owner withdraws; nothing here buffers data.
module mux8_rr_scheduler #(
    parameter int BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       out_valid,
    output logic       busy,
    output logic       fsm_state
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    // Beat count at which the accepted beat is the last of the burst.
    localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

    logic [0:0] state;
    logic [2:0] ptr;
    logic [7:0] beats;

    logic [2:0] winner;
    logic [2:0] scan_idx;
    logic       owner_req;
    logic       beat;
    logic       last_beat;
    logic       release_now;
    logic       start;

    // Rotating priority scan: the lowest offset from ptr with a request wins.
    // Walking offsets from 7 down to 0 lets the closest one overwrite the rest.
    always_comb begin
        winner   = ptr;
        scan_idx = ptr;
        for (int k = 7; k >= 0; k--) begin
            scan_idx = ptr + 3'(k);
            if (req[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    // Handshake and release decode for the current owner.
    always_comb begin
        owner_req   = req[sel];
        out_valid   = (state == S_GRANT) && owner_req;
        beat        = out_valid && out_ready;
        last_beat   = beat && (beats == LAST_BEAT);
        release_now = (state == S_GRANT) && (last_beat || !owner_req);
        start       = (state == S_IDLE) && en && (req != 8'd0);
    end

    assign fsm_state = state;

    // Grant/release state machine; sel is left alone on release so the mux
    // keeps pointing at the last owner while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sel   <= 3'd0;
            grant <= 8'd0;
            busy  <= 1'b0;
            ptr   <= 3'd0;
            beats <= 8'd0;
        end else if (state == S_IDLE) begin
            if (start) begin
                state <= S_GRANT;
                sel   <= winner;
                grant <= 8'd1 << winner;
                busy  <= 1'b1;
                beats <= 8'd0;
            end
        end else begin
            if (release_now) begin
                state <= S_IDLE;
                grant <= 8'd0;
                busy  <= 1'b0;
                ptr   <= sel + 3'd1;
                beats <= 8'd0;
            end else if (beat) begin
                beats <= beats + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: two instances (BURST=4 and BURST=1) share the
// same stimulus and are each compared every cycle against a behavioural
// model of the arbitration rules, plus directed expectations per scenario.
module tb_mux8_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] req = 8'd0;

    logic [2:0] sel_a, sel_b;
    logic [7:0] grant_a, grant_b;
    logic       ov_a, ov_b, busy_a, busy_b, st_a, st_b;

    int total = 0;
    int bad = 0;

    // clock
    always #5 clk = ~clk;

    mux8_rr_scheduler #(.BURST(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
        .sel(sel_a), .grant(grant_a), .out_valid(ov_a), .busy(busy_a), .fsm_state(st_a)
    );

    mux8_rr_scheduler #(.BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
        .sel(sel_b), .grant(grant_b), .out_valid(ov_b), .busy(busy_b), .fsm_state(st_b)
    );

    // ---------------- reference model ----------------
    // Per instance: who owns the mux (if anyone), where the next scan starts,
    // and how many beats the current owner has delivered.
    bit m_busy[2];
    int m_sel[2];
    int m_ptr[2];
    int m_beats[2];
    int m_burst[2] = '{4, 1};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d]  = 1'b0;
            m_sel[d]   = 0;
            m_ptr[d]   = 0;
            m_beats[d] = 0;
        end
    endtask

    task automatic model_release(input int d);
        m_busy[d]  = 1'b0;
        m_ptr[d]   = (m_sel[d] + 1) % 8;
        m_beats[d] = 0;
    endtask

    // Applies the rules for one clock edge using the inputs currently driven.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (!m_busy[d]) begin
                if (en && req != 8'd0) begin
                    for (int k = 0; k < 8; k++) begin
                        int idx;
                        idx = (m_ptr[d] + k) % 8;
                        if (req[idx]) begin
                            m_sel[d] = idx;
                            break;
                        end
                    end
                    m_busy[d]  = 1'b1;
                    m_beats[d] = 0;
                end
            end else if (!req[m_sel[d]]) begin
                model_release(d);
            end else if (out_ready) begin
                if (m_beats[d] + 1 == m_burst[d]) model_release(d);
                else m_beats[d] = m_beats[d] + 1;
            end
        end
    endtask

    // Expected {fsm_state, busy, grant, sel, out_valid}.
    function automatic logic [13:0] exp_vec(input int d);
        logic [7:0] g;
        logic [2:0] s;
        g = m_busy[d] ? (8'd1 << m_sel[d]) : 8'd0;
        s = 3'(m_sel[d]);
        return {m_busy[d], m_busy[d], g, s, m_busy[d] & req[m_sel[d]]};
    endfunction

    function automatic logic [13:0] obs_vec(input int d);
        if (d == 0) return {st_a, busy_a, grant_a, sel_a, ov_a};
        return {st_b, busy_b, grant_b, sel_b, ov_b};
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; leaves 1 time unit for outputs to settle.
    task automatic drive(input logic [7:0] r, input logic e, input logic o);
        req = r;
        en = e;
        out_ready = o;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Reset for one cycle, released on a falling edge.
    task automatic do_reset();
        req = 8'd0;
        en = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs_vec(d) !== 14'd0) begin
                bad++;
                $display("FAIL reset_init dut%0d got %h want %h", d, obs_vec(d), 14'd0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Owner 5 takes two beats, then reset lands mid-cycle.
        for (int c = 0; c < 3; c++) begin
            drive(8'h20, 1'b1, 1'b1);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL reset_pre dut%0d cyc%0d got %h want %h", d, c, obs_vec(d), exp_vec(d));
                end
            end
            advance();
        end
        drive(8'h20, 1'b1, 1'b1);
        total++;
        if (grant_a !== 8'h20 || busy_a !== 1'b1) begin
            bad++;
            $display("FAIL reset_midburst_owner got grant=%h busy=%b want grant=20 busy=1", grant_a, busy_a);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs_vec(d) !== 14'd0) begin
                bad++;
                $display("FAIL reset_async dut%0d got %h want %h", d, obs_vec(d), 14'd0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h20, 1'b1, 1'b1);
        advance();
        drive(8'h20, 1'b1, 1'b1);
        total++;
        if (grant_a !== 8'h20 || sel_a !== 3'd5 || grant_b !== 8'h20) begin
            bad++;
            $display("FAIL reset_regrant got a=%h sel=%0d b=%h want 20 5 20", grant_a, sel_a, grant_b);
        end
        advance();
    endtask

    task automatic test_single();
        logic [7:0] exp_g[8] = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 8'h08};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(8'h08, 1'b1, 1'b1);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL single dut%0d cyc%0d got %h want %h", d, c, obs_vec(d), exp_vec(d));
                end
            end
            total++;
            if (grant_a !== exp_g[c]) begin
                bad++;
                $display("FAIL single_grant cyc%0d got %h want %h", c, grant_a, exp_g[c]);
            end
            advance();
        end
    endtask

    task automatic test_rotation();
        logic [7:0] want;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            drive(8'hFF, 1'b1, 1'b1);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL rotation dut%0d cyc%0d got %h want %h", d, c, obs_vec(d), exp_vec(d));
                end
            end
            want = (c % 2 == 1) ? (8'd1 << ((c / 2) % 8)) : 8'd0;
            total++;
            if (grant_b !== want) begin
                bad++;
                $display("FAIL rotation_b1 cyc%0d got %h want %h", c, grant_b, want);
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_g[10] = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02};
        logic [7:0] r;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            r = (c == 0) ? 8'h20 : (c == 1) ? 8'h00 : 8'h03;
            drive(r, 1'b1, 1'b1);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL wrap dut%0d cyc%0d got %h want %h", d, c, obs_vec(d), exp_vec(d));
                end
            end
            total++;
            if (grant_a !== exp_g[c]) begin
                bad++;
                $display("FAIL wrap_grant cyc%0d got %h want %h", c, grant_a, exp_g[c]);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_g[8] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h08, 8'h08};
        logic       exp_v[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(8'h04, 1'b1, 1'b0);
            else if (c == 4) drive(8'h00, 1'b1, 1'b0);
            else drive(8'h0C, 1'b1, 1'b1);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL backpressure dut%0d cyc%0d got %h want %h", d, c, obs_vec(d), exp_vec(d));
                end
            end
            total++;
            if (grant_a !== exp_g[c] || ov_a !== exp_v[c]) begin
                bad++;
                $display("FAIL backpressure_a cyc%0d got %h/%b want %h/%b", c, grant_a, ov_a, exp_g[c], exp_v[c]);
            end
            advance();
        end
    endtask

    task automatic test_en_gating();
        logic [7:0] exp_g[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10,
                                  8'h00, 8'h00, 8'h00};
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drive(8'h10, (c == 3), 1'b1);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL en_gating dut%0d cyc%0d got %h want %h", d, c, obs_vec(d), exp_vec(d));
                end
            end
            total++;
            if (grant_a !== exp_g[c]) begin
                bad++;
                $display("FAIL en_grant cyc%0d got %h want %h", c, grant_a, exp_g[c]);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       e;
        logic       o;
        do_reset();
        r = 8'($urandom_range(0, 255));
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            if ($urandom_range(0, 9) < 3) r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) < 2) r = r ^ (8'd1 << $urandom_range(0, 7));
            e = ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 2) != 0);
            drive(r, e, o);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL random dut%0d cyc%0d got %h want %h", d, c, obs_vec(d), exp_vec(d));
                end
            end
            advance();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_backpressure();
        test_en_gating();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
